// File: rtl/alu_md_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op encoding follows RV32M funct3 so the decoder can pass it straight through.
package alu_md_pkg;

  localparam int REG_LEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Control captured at the accepting edge and held for the whole operation
  typedef struct packed {
    md_op_e op;
    logic   neg1;     // rs1 was negative (remainder sign)
    logic   neg_res;  // product / quotient must be negated
    logic   ovf;      // signed most-negative / -1 division
  } md_ctl_t;

  function automatic logic op_signed1(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed2(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_md.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes, then a
// single fix-up cycle for signs and RV32M divide corner cases.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN = REG_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_in1,
  input  logic [XLEN-1:0] md_in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] md_out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state;
  logic [CW-1:0]     cnt;
  md_ctl_t           ctl;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   opnd;   // multiplicand for mul, divisor for div
  logic [2*XLEN-1:0] acc;    // {hi, lo}: product, or {remainder, quotient}

  // Operand decode at the accepting edge
  md_op_e          op_in;
  logic            neg1_in, neg2_in, ovf_in;
  logic [XLEN-1:0] mag1_in, mag2_in;

  always_comb begin
    op_in   = md_op_e'(md_op);
    neg1_in = op_signed1(op_in) & md_in1[XLEN-1];
    neg2_in = op_signed2(op_in) & md_in2[XLEN-1];
    mag1_in = neg1_in ? -md_in1 : md_in1;
    mag2_in = neg2_in ? -md_in2 : md_in2;
    ovf_in  = (op_in == MD_DIV || op_in == MD_REM) &&
              (md_in1 == MIN_NEG) && (&md_in2);
  end

  // One iteration step for each datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opnd};
    // Restoring: keep the shifted remainder when the trial subtract underflows
    div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    step     = op_is_div(ctl.op) ? div_next : mul_next;
  end

  // Sign correction and special cases applied in FIX
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  always_comb begin
    prod = ctl.neg_res ? -acc : acc;
    quo  = ctl.neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = ctl.neg1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (opnd == '0) begin
      quo = '1;
      rem = rs1;
    end else if (ctl.ovf) begin
      quo = rs1;
      rem = '0;
    end
    case (ctl.op)
      MD_MUL:                      result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = quo;
      default:                     result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      ctl    <= '0;
      rs1    <= '0;
      opnd   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      md_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && !kill) begin
            ctl.op      <= op_in;
            ctl.neg1    <= neg1_in;
            ctl.neg_res <= neg1_in ^ neg2_in;
            ctl.ovf     <= ovf_in;
            rs1         <= md_in1;
            opnd        <= op_is_div(op_in) ? mag2_in : mag1_in;
            acc         <= {{XLEN{1'b0}}, (op_is_div(op_in) ? mag1_in : mag2_in)};
            cnt         <= CW'(XLEN - 1);
            state       <= MD_CALC;
            busy        <= 1'b1;
          end
        end
        MD_CALC: begin
          if (kill) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step;
            if (cnt == '0) state <= MD_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        MD_FIX: begin
          if (kill) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            md_out <= result;
            done   <= 1'b1;
            state  <= MD_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: a cycle-timeline reference model checked every
// cycle, plus literal expectations for results and done timing.
module tb_alu_md;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst, start, kill;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_in1, md_in2;
  logic            busy, done;
  logic [XLEN-1:0] md_out;

  int tests = 0;
  int fails = 0;

  alu_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .md_op(md_op),
    .md_in1(md_in1), .md_in2(md_in2), .busy(busy), .done(done), .md_out(md_out)
  );

  always #5 clk = ~clk;

  // RV32M semantics straight from 64-bit arithmetic
  function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timeline model: age = cycle number since the accepting edge, -1 when idle
  int          age = -1;
  bit          model_on = 0;
  bit          m_busy = 0, m_done = 0;
  logic [31:0] m_out = '0, pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      age = -1; m_out = '0;
    end else if (age < 0) begin
      if (start && !kill) begin
        age  = 1;
        pend = ref_md(md_op, md_in1, md_in2);
      end
    end else if (kill && age <= XLEN + 1) begin
      age = -1;
    end else begin
      age++;
      if (age == LAT) m_out = pend;
      if (age > LAT) age = -1;
    end
    m_busy   = (age > 0);
    m_done   = (age == LAT);
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      tests++;
      if ({busy, done, md_out} !== {m_busy, m_done, m_out}) begin
        fails++;
        $display("FAIL model_cmp t=%0t busy/done/out got %b/%b/%h want %b/%b/%h",
                 $time, busy, done, md_out, m_busy, m_done, m_out);
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; md_in1 = a; md_in2 = b;
    @(posedge clk); #1;
    start  = 1'b0;
    md_op  = 3'($urandom);
    md_in1 = $urandom;
    md_in2 = $urandom;
  endtask

  // Caller is #1 into cycle 'first' of the operation
  task automatic wait_done(string name, int first, logic [31:0] exp);
    bit got = 0;
    int cyc = -1;
    for (int i = first; i <= LAT + 10; i++) begin
      @(negedge clk);
      if (done) begin got = 1; cyc = i; break; end
    end
    chk({name, "_cycle"}, 64'(cyc), 64'(LAT));
    chk(name, {32'b0, md_out}, {32'b0, exp});
    @(posedge clk); #1;
  endtask

  typedef struct { logic [2:0] op; logic [31:0] a, b, exp; string name; } vec_t;
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2"};
    vecs[6]  = '{3'd5, 32'd7,          32'd2,         32'd3,         "divu_7_2"};
    vecs[7]  = '{3'd7, 32'd7,          32'd2,         32'd1,         "remu_7_2"};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0"};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         "rem_by0"};
    vecs[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf"};
    vecs[11] = '{3'd6, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, "rem_neg_by0"};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};

    rst = 1'b1; start = 1'b0; kill = 1'b0; md_op = '0; md_in1 = '0; md_in2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {30'b0, busy, done, md_out}, 64'h0);

    foreach (vecs[i]) begin
      chk({"ref_", vecs[i].name}, {32'b0, ref_md(vecs[i].op, vecs[i].a, vecs[i].b)},
          {32'b0, vecs[i].exp});
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, 1, vecs[i].exp);
    end

    // Kill a DIV at cycle 10: no done, md_out keeps the previous result
    begin
      int pulses = 0;
      issue(3'd4, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", {63'b0, busy}, 64'h0);
      chk("kill_out", {32'b0, md_out}, 64'h8000_0000);
      for (int i = 0; i < LAT + 5; i++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      chk("kill_no_done", 64'(pulses), 64'h0);
    end

    // Start pulsed mid-operation is ignored
    issue(3'd5, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; md_op = 3'd0; md_in1 = 32'd5; md_in2 = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done("divu_ign_start", 6, 32'd14);

    issue(3'd0, 32'd3, 32'd4);
    wait_done("mul_3_4", 1, 32'd12);

    // kill beats start in IDLE
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; md_op = 3'd0; md_in1 = 32'd2; md_in2 = 32'd2;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_start_idle", {62'b0, busy, done}, 64'h0);

    // Reset mid-MUL at cycle 20
    issue(3'd0, 32'h1234, 32'h5678);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_op", {30'b0, busy, done, md_out}, 64'h0);

    issue(3'd5, 32'd1000, 32'd10);
    wait_done("divu_after_rst", 1, 32'd100);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
